mux_operand_loader: RTL and testbench
=====================================

# mux_operand_loader

Upstream operand-capture stage for the 8-bit 2:1 operand mux (`mux_8_1`). It takes raw board switches and two raw pushbuttons and drives the mux's `x`, `y` and `s` inputs.
- Each button is synchronised, debounced and edge-detected.
- A load state machine captures the switch value into `x` on the first press and into `y` on the second, then flags `ready`.
- The select button toggles `s`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a synchronised button level must differ from its debounced level before the debounced level changes. Legal range is ≥ 1; the bench uses 4.

Ports:
- `clk`  in  1  system clock; every flop is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `sw`  in  8  operand value from the switches; sampled directly, with no synchroniser.
- `load_btn`  in  1  raw load button, active-high, asynchronous to `clk`.
- `sel_btn`  in  1  raw select button, active-high, asynchronous to `clk`.
- `x`  out  8  operand A, drives mux `x`.
- `y`  out  8  operand B, drives mux `y`.
- `s`  out  1  mux select.
- `ready`  out  1  high when both operands have been loaded.
- `load_state`  out  2  current load FSM state code.

## Operation
**Button path** (identical for `load_btn` and `sel_btn`):
- 2-flop synchroniser: `sync1` ← raw, `sync2` ← `sync1`.
- Debounce counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, and debounced level `stable`. At each edge:
  - if `sync2` ≠ `stable`: when `cnt == DEBOUNCE_CYCLES-1`, set `stable` ← `sync2` and `cnt` ← 0; otherwise `cnt` ← `cnt`+1.
  - if `sync2` = `stable`: `cnt` ← 0.
- `stable_d` ← `stable`. Press pulse = `stable & ~stable_d`, which is exactly one cycle per press.
- Release and hold produce no pulse. A bounce or glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored.

**Load FSM** (state codes are driven on `load_state`):
- `WAIT_X` (2'b00): on load pulse, `x` ← `sw`, go to `WAIT_Y`.
- `WAIT_Y` (2'b01): on load pulse, `y` ← `sw`, go to `READY`.
- `READY` (2'b10): on load pulse, `x` ← `sw` and go to `WAIT_Y`. This starts a new pair; `y` keeps its old value until reloaded.
- No load pulse: hold state and registers.
- 2'b11 is unreachable; if entered, go to `WAIT_X` on the next edge.
- `ready` = (state == `READY`), registered-state decode with no extra latency.

**Select:**
- A sel pulse toggles `s` in any state.
- A load pulse and a sel pulse in the same cycle: both take effect on that edge.

**Reset** (`rst` high at an edge):
- `x`=0, `y`=0, `s`=0, `ready`=0, `load_state`=2'b00.
- All sync flops, `stable`, `stable_d` and `cnt` are cleared to 0.
- Reset overrides any pending pulse or count.
- A button still held when `rst` drops is seen as a new press, because `stable` restarts at 0.

## Timing
- Let edge k be the first edge at which `sync1` samples a raw rising level.
  - `sync2`=1 after edge k+1.
  - `stable`=1 after edge k+1+`DEBOUNCE_CYCLES`.
  - Pulse is high during the following cycle.
  - `x`/`y`/`s`/state update at edge k+2+`DEBOUNCE_CYCLES`.
- All outputs are registered or decoded from registered state; there are no combinational paths from `sw` or the buttons to outputs.
- `sw` is captured on the update edge itself, so `sw` must be stable around that edge. No settling is required earlier.
- Minimum spacing between two accepted presses of one button: 2×`DEBOUNCE_CYCLES` cycles (press debounce plus release debounce).

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
1. **Reset:** hold `rst` 3 cycles with buttons toggling → `x`=0x00, `y`=0x00, `s`=0, `ready`=0, `load_state`=00 throughout, and one cycle after `rst` drops with buttons low.
2. **Load sequence:**
   - `sw`=0xA5, `load_btn` high for 12 cycles → `x`=0xA5 exactly at edge k+6, `load_state`=01, `y` still 0x00, and no further change while held.
   - Release, then `sw`=0x3C with a second press → `y`=0x3C, `ready`=1, `load_state`=10.
3. **Glitch rejection:** `load_btn` high for 3 cycles, then low → no change to `x`, `y` or state. A 5-cycle pulse → exactly one load.
4. **Select and simultaneity:**
   - Two separate `sel_btn` presses → `s` goes 0→1→0.
   - In `READY` with `x`=0xA5, `y`=0x3C: `sw`=0xFF, and `load_btn` and `sel_btn` rise on the same cycle → on the same edge `x`=0xFF, `s` toggles, `ready`=0, `load_state`=01, `y`=0x3C.
5. **Reset mid-operation:**
   - In `WAIT_Y` with `load_btn` held, assert `rst` for 1 cycle → all outputs return to reset values.
   - After `rst` drops with the button still held and `sw`=0x5A → `x`=0x5A at the 7th edge after release (k+6), `load_state`=01.

Source files
------------

// File: rtl/mux_operand_loader.sv
// mux_operand_loader: debounced button-driven capture of mux operands x/y and select s
module mux_operand_btn #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1_q, sync2_q, stable_q, stable_d, stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic diff;
  always_comb begin
    diff     = sync2_q != stable_q;
    cnt_d    = (!diff || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    stable_d = (diff && cnt_q == LAST) ? sync2_q : stable_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end
  assign pulse_o = stable_q & ~stable_dly_q;
endmodule

module mux_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       load_btn,
  input  logic       sel_btn,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       s,
  output logic       ready,
  output logic [1:0] load_state
);
  localparam logic [1:0] WAIT_X = 2'b00;
  localparam logic [1:0] WAIT_Y = 2'b01;
  localparam logic [1:0] READY  = 2'b10;
  logic load_p, sel_p;
  logic [1:0] state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic s_q, s_d;
  mux_operand_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk(clk), .rst(rst), .btn_i(load_btn), .pulse_o(load_p)
  );
  mux_operand_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk(clk), .rst(rst), .btn_i(sel_btn), .pulse_o(sel_p)
  );
  // READY reloads x and reopens WAIT_Y, leaving y until the next press
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q ^ sel_p;
    if (state_q == 2'b11) state_d = WAIT_X;
    else if (load_p) begin
      state_d = (state_q == WAIT_Y) ? READY : WAIT_Y;
      x_d     = (state_q == WAIT_Y) ? x_q : sw;
      y_d     = (state_q == WAIT_Y) ? sw : y_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_X;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
    end
  end
  assign x          = x_q;
  assign y          = y_q;
  assign s          = s_q;
  assign ready      = state_q == READY;
  assign load_state = state_q;
endmodule

// File: tb/tb_mux_operand_loader.sv
// tb_mux_operand_loader: directed checks of debounce timing, load FSM and select toggle
module tb_mux_operand_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       load_btn = 1'b0;
  logic       sel_btn = 1'b0;
  logic [7:0] x, y;
  logic       s, ready;
  logic [1:0] load_state;
  logic [19:0] obs;
  int cmp_n = 0;
  int err_n = 0;

  mux_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .load_btn(load_btn), .sel_btn(sel_btn),
    .x(x), .y(y), .s(s), .ready(ready), .load_state(load_state)
  );

  always #5 clk = ~clk;
  assign obs = {x, y, s, ready, load_state};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_btn = i[0];
      sel_btn  = ~i[0];
      tick();
      cmp_n++;
      if (obs !== 20'h0) begin
        err_n++;
        $display("FAIL reset_hold[%0d] got %h expected %h", i, obs, 20'h0);
      end
    end
    rst = 1'b0;
    load_btn = 1'b0;
    sel_btn = 1'b0;
    tick();
    cmp_n++;
    if (obs !== 20'h0) begin
      err_n++;
      $display("FAIL reset_release got %h expected %h", obs, 20'h0);
    end
  endtask

  task automatic test_load();
    sw = 8'hA5;
    load_btn = 1'b1;
    repeat (6) tick();
    cmp_n++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b0, 2'b00}) begin
      err_n++;
      $display("FAIL load_x_early got %h expected %h", obs, {8'h00, 8'h00, 1'b0, 1'b0, 2'b00});
    end
    tick();
    cmp_n++;
    if (obs !== {8'hA5, 8'h00, 1'b0, 1'b0, 2'b01}) begin
      err_n++;
      $display("FAIL load_x_edge got %h expected %h", obs, {8'hA5, 8'h00, 1'b0, 1'b0, 2'b01});
    end
    repeat (5) tick();
    cmp_n++;
    if (obs !== {8'hA5, 8'h00, 1'b0, 1'b0, 2'b01}) begin
      err_n++;
      $display("FAIL load_x_hold got %h expected %h", obs, {8'hA5, 8'h00, 1'b0, 1'b0, 2'b01});
    end
    load_btn = 1'b0;
    repeat (12) tick();
    sw = 8'h3C;
    load_btn = 1'b1;
    repeat (7) tick();
    cmp_n++;
    if (obs !== {8'hA5, 8'h3C, 1'b0, 1'b1, 2'b10}) begin
      err_n++;
      $display("FAIL load_y got %h expected %h", obs, {8'hA5, 8'h3C, 1'b0, 1'b1, 2'b10});
    end
    load_btn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_glitch();
    load_btn = 1'b1;
    repeat (3) tick();
    load_btn = 1'b0;
    repeat (12) tick();
    cmp_n++;
    if (obs !== {8'hA5, 8'h3C, 1'b0, 1'b1, 2'b10}) begin
      err_n++;
      $display("FAIL glitch_reject got %h expected %h", obs, {8'hA5, 8'h3C, 1'b0, 1'b1, 2'b10});
    end
    sw = 8'h77;
    load_btn = 1'b1;
    repeat (5) tick();
    load_btn = 1'b0;
    repeat (2) tick();
    cmp_n++;
    if (obs !== {8'h77, 8'h3C, 1'b0, 1'b0, 2'b01}) begin
      err_n++;
      $display("FAIL glitch_5cyc_load got %h expected %h", obs, {8'h77, 8'h3C, 1'b0, 1'b0, 2'b01});
    end
    repeat (12) tick();
    cmp_n++;
    if (obs !== {8'h77, 8'h3C, 1'b0, 1'b0, 2'b01}) begin
      err_n++;
      $display("FAIL glitch_single_load got %h expected %h", obs, {8'h77, 8'h3C, 1'b0, 1'b0, 2'b01});
    end
  endtask

  task automatic test_select();
    sel_btn = 1'b1;
    repeat (7) tick();
    cmp_n++;
    if (obs !== {8'h77, 8'h3C, 1'b1, 1'b0, 2'b01}) begin
      err_n++;
      $display("FAIL sel_first got %h expected %h", obs, {8'h77, 8'h3C, 1'b1, 1'b0, 2'b01});
    end
    sel_btn = 1'b0;
    repeat (12) tick();
    sel_btn = 1'b1;
    repeat (6) tick();
    cmp_n++;
    if (obs !== {8'h77, 8'h3C, 1'b1, 1'b0, 2'b01}) begin
      err_n++;
      $display("FAIL sel_second_early got %h expected %h", obs, {8'h77, 8'h3C, 1'b1, 1'b0, 2'b01});
    end
    tick();
    cmp_n++;
    if (obs !== {8'h77, 8'h3C, 1'b0, 1'b0, 2'b01}) begin
      err_n++;
      $display("FAIL sel_second got %h expected %h", obs, {8'h77, 8'h3C, 1'b0, 1'b0, 2'b01});
    end
    sel_btn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sw = 8'hA5;
    load_btn = 1'b1;
    repeat (7) tick();
    load_btn = 1'b0;
    repeat (12) tick();
    sw = 8'h3C;
    load_btn = 1'b1;
    repeat (7) tick();
    load_btn = 1'b0;
    repeat (12) tick();
    cmp_n++;
    if (obs !== {8'hA5, 8'h3C, 1'b0, 1'b1, 2'b10}) begin
      err_n++;
      $display("FAIL simul_setup got %h expected %h", obs, {8'hA5, 8'h3C, 1'b0, 1'b1, 2'b10});
    end
    sw = 8'hFF;
    load_btn = 1'b1;
    sel_btn = 1'b1;
    repeat (6) tick();
    cmp_n++;
    if (obs !== {8'hA5, 8'h3C, 1'b0, 1'b1, 2'b10}) begin
      err_n++;
      $display("FAIL simul_early got %h expected %h", obs, {8'hA5, 8'h3C, 1'b0, 1'b1, 2'b10});
    end
    tick();
    cmp_n++;
    if (obs !== {8'hFF, 8'h3C, 1'b1, 1'b0, 2'b01}) begin
      err_n++;
      $display("FAIL simul_edge got %h expected %h", obs, {8'hFF, 8'h3C, 1'b1, 1'b0, 2'b01});
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    sel_btn = 1'b0;
    tick();
    cmp_n++;
    if (obs !== 20'h0) begin
      err_n++;
      $display("FAIL mid_reset got %h expected %h", obs, 20'h0);
    end
    sw = 8'h5A;
    rst = 1'b0;
    repeat (6) tick();
    cmp_n++;
    if (obs !== 20'h0) begin
      err_n++;
      $display("FAIL mid_reset_early got %h expected %h", obs, 20'h0);
    end
    tick();
    cmp_n++;
    if (obs !== {8'h5A, 8'h00, 1'b0, 1'b0, 2'b01}) begin
      err_n++;
      $display("FAIL mid_reset_reload got %h expected %h", obs, {8'h5A, 8'h00, 1'b0, 1'b0, 2'b01});
    end
    load_btn = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_glitch();
    test_select();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
